// File: rtl/snes_video_pkg.sv
// Shared video types and helpers for the SNES->HDMI path.
//   rgb555_t       : SNES pixel, {b5,g5,r5}
//   rgb888_t       : HDMI pixel, {r8,g8,b8}
//   expand5to8     : 5:5:5 -> 8:8:8 by MSB replication
//   dim_half       : halve each 8-bit channel (scanline effect)
//   SCALER_LATENCY : cycles from cx/cy to rgb in the read-side scaler
package snes_video_pkg;

  typedef logic [14:0] rgb555_t;
  typedef logic [23:0] rgb888_t;

  localparam int SCALER_LATENCY = 2;

  // Replicating the top bits keeps full-scale 5'h1F at 8'hFF and 0 at 0.
  function automatic rgb888_t expand5to8(input rgb555_t c);
    return {c[4:0], c[4:2], c[9:5], c[9:7], c[14:10], c[14:12]};
  endfunction

  function automatic rgb888_t dim_half(input rgb888_t c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction

endpackage

// File: rtl/snes_scaler_rd_scale_counter.sv
// Sub-pixel / source-pixel counter pair for one scaling axis.
//   clk, reset : clock, async active-high reset
//   clr        : restart at 0 this cycle (outputs read as 0 immediately)
//   adv        : consume one output pixel/row this cycle
//   sub        : replica index within the current source pixel, 0..SCALE-1
//   src        : current source pixel/line index
//   last_sub   : sub is on the final replica of src
// sub/src are the values in effect for the current cycle: a clear is
// visible combinationally so the first window pixel reads address 0, and
// an advance in the same cycle steps from that cleared value.
module scale_counter #(
  parameter int SCALE = 3,
  parameter int SRC_W = 256,
  localparam int SRC_BITS = $clog2(SRC_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                adv,
  output logic [2:0]          sub,
  output logic [SRC_BITS-1:0] src,
  output logic                last_sub
);

  logic [2:0]          sub_q;
  logic [SRC_BITS-1:0] src_q;

  assign sub      = clr ? '0 : sub_q;
  assign src      = clr ? '0 : src_q;
  assign last_sub = (sub == 3'(SCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_q <= '0;
      src_q <= '0;
    end else if (adv) begin
      if (last_sub) begin
        sub_q <= '0;
        src_q <= src + 1'b1;
      end else begin
        sub_q <= sub + 3'd1;
        src_q <= src;
      end
    end else if (clr) begin
      sub_q <= '0;
      src_q <= '0;
    end
  end

endmodule

// File: rtl/snes_scaler_rd.sv
// Read side of the SNES->HDMI line buffer, pixel clock domain.
// Maps HDMI raster (cx, cy) onto a centred integer-scaled SNES window,
// issues line-buffer reads, expands 5:5:5 to 8:8:8 with optional scanline
// dimming and overlay, and flags line/frame progress to the writer.
//   clk_pixel, reset      : pixel clock, async active-high reset
//   cx, cy                : HDMI raster position
//   scanline_en           : dim the last replicated row of each source line
//   overlay, overlay_color: replace buffer data with a fixed 5:5:5 colour
//   mem_rd_addr/_data     : BRAM port, {slot, x_src}; data 1 cycle later
//   rgb                   : {r8,g8,b8}, 2 cycles after cx/cy
//   line_done             : pulse on the final read of a source line
//   frame_start           : pulse at the first active window pixel
//   src_y                 : source line currently being read
module snes_scaler_rd
  import snes_video_pkg::*;
#(
  parameter int          FRAME_W        = 1280,
  parameter int          FRAME_H        = 720,
  parameter int          SRC_W          = 256,
  parameter int          SRC_H          = 224,
  parameter int          SCALE          = 3,
  parameter int          BUF_LINES_LOG2 = 4,
  parameter logic [23:0] BORDER_RGB     = 24'h303030,
  localparam int         XW             = $clog2(SRC_W),
  localparam int         AW             = BUF_LINES_LOG2 + XW
) (
  input  logic          clk_pixel,
  input  logic          reset,
  input  logic [10:0]   cx,
  input  logic [9:0]    cy,
  input  logic          scanline_en,
  input  logic          overlay,
  input  logic [14:0]   overlay_color,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [14:0]   mem_rd_data,
  output logic [23:0]   rgb,
  output logic          line_done,
  output logic          frame_start,
  output logic [7:0]    src_y
);

  localparam int X0 = (FRAME_W - SRC_W * SCALE) / 2;
  localparam int Y0 = (FRAME_H - SRC_H * SCALE) / 2;
  localparam int X1 = X0 + SRC_W * SCALE;
  localparam int Y1 = Y0 + SRC_H * SCALE;
  localparam int Y_SPAN = 256;  // y counter range matches the 8-bit src_y

  if (SRC_W * SCALE > FRAME_W || SRC_H * SCALE > FRAME_H) begin : g_bad_fit
    $error("snes_scaler_rd: scaled source does not fit the frame");
  end
  if (SCALE < 1 || SCALE > 7) begin : g_bad_scale
    $error("snes_scaler_rd: SCALE must be 1..7");
  end

  // ---------------- stage 0: raster decode and counters ----------------
  logic in_rows, in_win, x_clr, y_clr, row_end;

  assign in_rows = (cy >= 10'(Y0)) && (cy < 10'(Y1));
  assign in_win  = in_rows && (cx >= 11'(X0)) && (cx < 11'(X1));
  assign x_clr   = (cx == 11'(X0));
  assign y_clr   = x_clr && (cy == 10'(Y0));
  assign row_end = in_rows && (cx == 11'(X1));

  logic [2:0]    x_sub, y_sub;
  logic [XW-1:0] x_src;
  logic [7:0]    y_src;
  logic          x_last, y_last;

  scale_counter #(.SCALE(SCALE), .SRC_W(SRC_W)) u_x_cnt (
    .clk(clk_pixel), .reset(reset), .clr(x_clr), .adv(in_win),
    .sub(x_sub), .src(x_src), .last_sub(x_last)
  );

  scale_counter #(.SCALE(SCALE), .SRC_W(Y_SPAN)) u_y_cnt (
    .clk(clk_pixel), .reset(reset), .clr(y_clr), .adv(row_end),
    .sub(y_sub), .src(y_src), .last_sub(y_last)
  );

  logic [AW-1:0] addr_cur, addr_hold;

  assign addr_cur    = {y_src[BUF_LINES_LOG2-1:0], x_src};
  assign mem_rd_addr = in_win ? addr_cur : addr_hold;
  assign src_y       = y_src;

  // Pulses are tied to the read being issued, so gate them off in reset
  // since cx/cy keep running regardless.
  assign frame_start = !reset && y_clr;
  assign line_done   = !reset && in_win && x_last && y_last &&
                       (x_src == XW'(SRC_W - 1));

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset)       addr_hold <= '0;
    else if (in_win) addr_hold <= addr_cur;
  end

  // ---------------- stage 1: sidebands alongside BRAM data -------------
  logic          vld_s1, in_win_d, ov_d, dim_d;
  logic [14:0]   ocol_d;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      vld_s1   <= 1'b0;
      in_win_d <= 1'b0;
      ov_d     <= 1'b0;
      dim_d    <= 1'b0;
      ocol_d   <= '0;
    end else begin
      vld_s1   <= 1'b1;
      in_win_d <= in_win;
      ov_d     <= overlay;
      dim_d    <= scanline_en && y_last;
      ocol_d   <= overlay_color;
    end
  end

  // ---------------- stage 2: colour select and register ----------------
  rgb888_t pix_c, mem_c;

  assign mem_c = expand5to8(mem_rd_data);

  always_comb begin
    pix_c = mem_c;
    if (!in_win_d)  pix_c = BORDER_RGB;
    else if (ov_d)  pix_c = expand5to8(ocol_d);
    else if (dim_d) pix_c = dim_half(mem_c);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset)       rgb <= '0;
    else if (vld_s1) rgb <= pix_c;
  end

endmodule

// File: tb/tb_snes_scaler_rd.sv
// Directed raster sweeps against snes_scaler_rd with a BRAM model and a
// scoreboard of expected rgb values, plus a small-frame instance used to
// count line_done / frame_start pulses over a whole frame.
module tb_snes_scaler_rd;

  logic        clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic        reset;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        scanline_en, overlay;
  logic [14:0] overlay_color, mem_rd_data;
  logic [11:0] mem_rd_addr;
  logic [23:0] rgb;
  logic        line_done, frame_start;
  logic [7:0]  src_y;

  snes_scaler_rd dut (
    .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy),
    .scanline_en(scanline_en), .overlay(overlay), .overlay_color(overlay_color),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .rgb(rgb),
    .line_done(line_done), .frame_start(frame_start), .src_y(src_y)
  );

  // small frame: X0=8, X1=32, Y0=3, Y1=27
  logic [10:0] scx;
  logic [9:0]  scy;
  logic [6:0]  s_addr;
  logic [23:0] s_rgb;
  logic        s_ld, s_fs;
  logic [7:0]  s_sy;

  snes_scaler_rd #(.FRAME_W(40), .FRAME_H(30), .SRC_W(8), .SRC_H(8), .SCALE(3),
                   .BUF_LINES_LOG2(4), .BORDER_RGB(24'h303030)) dut_s (
    .clk_pixel(clk_pixel), .reset(reset), .cx(scx), .cy(scy),
    .scanline_en(1'b0), .overlay(1'b0), .overlay_color(15'h0),
    .mem_rd_addr(s_addr), .mem_rd_data(15'h0), .rgb(s_rgb),
    .line_done(s_ld), .frame_start(s_fs), .src_y(s_sy)
  );

  // BRAM model: mode 0 returns the address, mode 1 a constant
  int          mode;
  logic [14:0] cdata;
  always @(posedge clk_pixel)
    mem_rd_data <= (mode == 0) ? {3'b000, mem_rd_addr} : cdata;

  int          nvec = 0, nerr = 0;
  logic [23:0] q[$];
  logic [11:0] hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] e8(input logic [4:0] c);
    return 8'(int'(c) * 8 + int'(c) / 4);
  endfunction

  function automatic logic [23:0] ex(input logic [14:0] d);
    return {e8(d[4:0]), e8(d[9:5]), e8(d[14:10])};
  endfunction

  function automatic logic [23:0] model(input int x, input int y);
    logic [23:0] c;
    logic [14:0] d;
    int xs, ys;
    if (!(x >= 256 && x < 1024 && y >= 24 && y < 696)) return 24'h303030;
    if (overlay) return ex(overlay_color);
    xs = (x - 256) / 3;
    ys = (y - 24) / 3;
    d  = (mode == 0) ? 15'((ys % 16) * 256 + xs) : cdata;
    c  = ex(d);
    if (scanline_en && ((y - 24) % 3) == 2)
      c = {c[23:16] / 8'd2, c[15:8] / 8'd2, c[7:0] / 8'd2};
    return c;
  endfunction

  task automatic step(input int x, input int y);
    logic        inw;
    logic [11:0] ea;
    int          xs, ys;
    @(posedge clk_pixel); #1;
    cx = 11'(x); cy = 10'(y);
    q.push_back(model(x, y));
    inw = (x >= 256 && x < 1024 && y >= 24 && y < 696);
    xs  = (x - 256) / 3;
    ys  = (y - 24) / 3;
    ea  = inw ? 12'((ys % 16) * 256 + xs) : hold;
    if (inw) hold = ea;
    @(negedge clk_pixel);
    chk($sformatf("addr(%0d,%0d)", x, y), 32'(mem_rd_addr), 32'(ea));
    chk($sformatf("line_done(%0d,%0d)", x, y), 32'(line_done),
        32'(inw && (x - 256) == 767 && ((y - 24) % 3) == 2));
    chk($sformatf("frame_start(%0d,%0d)", x, y), 32'(frame_start), 32'(x == 256 && y == 24));
    if (inw) chk($sformatf("src_y(%0d,%0d)", x, y), 32'(src_y), 32'(ys));
    if (q.size() == 3) chk($sformatf("rgb@(%0d,%0d)", x, y), 32'(rgb), 32'(q.pop_front()));
  endtask

  task automatic row(input int y);
    for (int x = 250; x <= 1030; x++) step(x, y);
  endtask

  task automatic setup(input int m, input logic [14:0] d, input logic sl,
                       input logic ov, input logic [14:0] oc);
    mode = m; cdata = d; scanline_en = sl; overlay = ov; overlay_color = oc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgb"}, 32'(rgb), 32'h0);
    chk({tag, "_line_done"}, 32'(line_done), 32'h0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
    chk({tag, "_addr"}, 32'(mem_rd_addr), 32'h0);
    chk({tag, "_src_y"}, 32'(src_y), 32'h0);
  endtask

  initial begin
    int nld, nfs;
    reset = 1'b1; cx = '0; cy = '0; scx = '0; scy = '0; hold = '0;
    setup(0, 15'h0, 1'b0, 1'b0, 15'h0);
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel);
    chk_zero("reset");
    reset = 1'b0;

    // address = data, plain expansion; rows 24..26 give the first line_done
    for (int y = 23; y <= 26; y++) row(y);
    // scanline dimming on the last replica row (29)
    setup(1, 15'h7FFF, 1'b1, 1'b0, 15'h0);
    for (int y = 27; y <= 29; y++) row(y);
    setup(1, 15'h7C1F, 1'b0, 1'b0, 15'h0);
    row(30);
    setup(1, 15'h0000, 1'b0, 1'b0, 15'h0);
    row(31);
    // overlay on a dim row is not dimmed
    setup(1, 15'h7FFF, 1'b1, 1'b1, 15'h001F);
    row(32);

    // async reset mid-frame: outputs drop without a clock edge
    @(posedge clk_pixel); #1;
    cx = 11'd600; cy = 10'd100; reset = 1'b1;
    q.delete(); hold = '0;
    #1 chk_zero("midreset");
    repeat (2) @(posedge clk_pixel);
    #1 reset = 1'b0;
    setup(0, 15'h0, 1'b0, 1'b0, 15'h0);
    for (int y = 24; y <= 26; y++) row(y);

    // whole small frame: expect SRC_H line_done pulses and one frame_start
    nld = 0; nfs = 0;
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 40; x++) begin
        @(posedge clk_pixel); #1;
        scx = 11'(x); scy = 10'(y);
        @(negedge clk_pixel);
        if (s_ld) begin
          nld++;
          if (nld == 1) chk("small_first_ld_pos", 32'(x * 100 + y), 32'(31 * 100 + 5));
        end
        if (s_fs) begin
          nfs++;
          chk("small_fs_pos", 32'(x * 100 + y), 32'(8 * 100 + 3));
        end
      end
    end
    chk("small_line_done_count", 32'(nld), 32'd8);
    chk("small_frame_start_count", 32'(nfs), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
